// File: rtl/fnd_scan_decoder_pkg.sv
// fnd_pkg: segment codes, digit-select codes and frame-sum helper shared by
// the FND scan decoder files.
package fnd_pkg;

  localparam int FND_DIGITS = 4;

  // Active-low segment patterns g..a with dp removed
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low digit selects: ones, tens, hundreds, thousands
  localparam logic [3:0] DIGIT_SEL_0 = 4'b1110;
  localparam logic [3:0] DIGIT_SEL_1 = 4'b1101;
  localparam logic [3:0] DIGIT_SEL_2 = 4'b1011;
  localparam logic [3:0] DIGIT_SEL_3 = 4'b0111;

  typedef enum logic {ST_COLLECT, ST_EMIT} fnd_state_e;

  // Four BCD digits to binary; max 9999 so 14 bits never overflow
  function automatic logic [13:0] bcd_weight(input logic [3:0] d3, input logic [3:0] d2,
                                             input logic [3:0] d1, input logic [3:0] d0);
    return 14'(d3) * 14'd1000 + 14'(d2) * 14'd100 + 14'(d1) * 14'd10 + 14'(d0);
  endfunction

endpackage

// File: rtl/fnd_scan_decoder_if.sv
// fnd_scan_decoder_if: FND pin inputs and decoded-frame outputs.
// master = pin driver / result consumer, slave = the decoder.
interface fnd_scan_decoder_if;
  logic [3:0]  fnd_digit;
  logic [7:0]  fnd_data;
  logic [13:0] o_value;
  logic        o_valid;
  logic        o_seg_err;
  logic [3:0]  o_blank;
  logic [3:0]  o_dot;

  modport master (output fnd_digit, fnd_data,
                  input  o_value, o_valid, o_seg_err, o_blank, o_dot);
  modport slave  (input  fnd_digit, fnd_data,
                  output o_value, o_valid, o_seg_err, o_blank, o_dot);
endinterface

// File: rtl/fnd_scan_decoder_seg_decode.sv
// fnd_seg_decode: active-low 7-segment pattern to BCD digit.
// All-off is reported as blank (digit 0); anything else unknown is an error.
module fnd_seg_decode
  import fnd_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       is_blank,
  output logic       is_err
);

  // Table lookup of the ten digit glyphs plus blank
  always_comb begin
    bcd      = 4'd0;
    is_blank = 1'b0;
    is_err   = 1'b0;
    case (seg)
      SEG_0:     bcd = 4'd0;
      SEG_1:     bcd = 4'd1;
      SEG_2:     bcd = 4'd2;
      SEG_3:     bcd = 4'd3;
      SEG_4:     bcd = 4'd4;
      SEG_5:     bcd = 4'd5;
      SEG_6:     bcd = 4'd6;
      SEG_7:     bcd = 4'd7;
      SEG_8:     bcd = 4'd8;
      SEG_9:     bcd = 4'd9;
      SEG_BLANK: is_blank = 1'b1;
      default:   is_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/fnd_scan_decoder.sv
// fnd_scan_decoder: watches multiplexed FND pins, debounces each digit
// position and emits the displayed 4-digit number once per full scan.
// Optional: FND_DP_CAPTURE_EN stores per-position dp and reports it on o_dot.
module fnd_scan_decoder
  import fnd_pkg::*;
#(
  parameter int STABLE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  fnd_scan_decoder_if.slave   bus
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

  logic [11:0] sync1, sync2, prev;
  logic [7:0]  cnt;
  logic        acc_done;
  logic        changed, take, cap;
  logic        pos_ok;
  logic [1:0]  pos;
  logic [3:0]  bcd;
  logic        is_blank, is_err;

  fnd_state_e                   state;
  logic [FND_DIGITS-1:0][3:0]   dig_q, dig_nx;
  logic [3:0]                   blank_q, blank_nx, mask_q, mask_nx;
  logic                         err_q, err_nx;
  logic [13:0]                  value_q;
  logic                         valid_q, seg_err_q;
  logic [3:0]                   blank_o, dot_o;

  // Two-flop synchronizer plus one-cycle history for change detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 12'hFFF;
      sync2 <= 12'hFFF;
      prev  <= 12'hFFF;
    end else begin
      sync1 <= {bus.fnd_digit, bus.fnd_data};
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign changed = (sync2 != prev);
  assign take    = !changed && (cnt == CNT_MAX) && !acc_done;

  // Stability counter; acc_done makes each stable period yield one acceptance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= 8'd0;
      acc_done <= 1'b0;
    end else if (changed) begin
      cnt      <= 8'd0;
      acc_done <= 1'b0;
    end else begin
      if (cnt != CNT_MAX) cnt <= cnt + 8'd1;
      if (take)           acc_done <= 1'b1;
    end
  end

  // Exactly-one-low digit select to position index
  always_comb begin
    pos_ok = 1'b1;
    pos    = 2'd0;
    case (sync2[11:8])
      DIGIT_SEL_0: pos = 2'd0;
      DIGIT_SEL_1: pos = 2'd1;
      DIGIT_SEL_2: pos = 2'd2;
      DIGIT_SEL_3: pos = 2'd3;
      default:     pos_ok = 1'b0;
    endcase
  end

  fnd_seg_decode u_seg_decode (
    .seg      (sync2[6:0]),
    .bcd      (bcd),
    .is_blank (is_blank),
    .is_err   (is_err)
  );

  assign cap = take && pos_ok;

  // Frame registers after this cycle's capture, used to emit the full frame
  always_comb begin
    dig_nx   = dig_q;
    blank_nx = blank_q;
    mask_nx  = mask_q;
    err_nx   = err_q;
    if (cap) begin
      dig_nx[pos]   = bcd;
      blank_nx[pos] = is_blank;
      mask_nx[pos]  = 1'b1;
      err_nx        = err_q | is_err;
    end
  end

`ifdef FND_DP_CAPTURE_EN
  logic [3:0] dot_q, dot_nx;

  // dp is active low on the pin; stored as 1 = lit
  always_comb begin
    dot_nx = dot_q;
    if (cap) dot_nx[pos] = ~sync2[7];
  end

  // Per-position dp store
  always_ff @(posedge clk or posedge reset) begin
    if (reset) dot_q <= 4'b0000;
    else       dot_q <= dot_nx;
  end
`else
  logic unused_dp;
  assign unused_dp = sync2[7];
`endif

  // Collect/emit FSM with registered frame outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_COLLECT;
      dig_q     <= '0;
      blank_q   <= 4'b0000;
      mask_q    <= 4'b0000;
      err_q     <= 1'b0;
      value_q   <= 14'd0;
      valid_q   <= 1'b0;
      seg_err_q <= 1'b0;
      blank_o   <= 4'b0000;
      dot_o     <= 4'b0000;
    end else begin
      case (state)
        ST_COLLECT: begin
          dig_q   <= dig_nx;
          blank_q <= blank_nx;
          mask_q  <= mask_nx;
          err_q   <= err_nx;
          valid_q <= 1'b0;
          if (mask_nx == 4'hF) begin
            state     <= ST_EMIT;
            valid_q   <= 1'b1;
            value_q   <= bcd_weight(dig_nx[3], dig_nx[2], dig_nx[1], dig_nx[0]);
            seg_err_q <= err_nx;
            blank_o   <= blank_nx;
`ifdef FND_DP_CAPTURE_EN
            dot_o     <= dot_nx;
`else
            dot_o     <= 4'b0000;
`endif
          end
        end
        ST_EMIT: begin
          valid_q <= 1'b0;
          mask_q  <= 4'b0000;
          err_q   <= 1'b0;
          state   <= ST_COLLECT;
        end
        default: state <= ST_COLLECT;
      endcase
    end
  end

  assign bus.o_value   = value_q;
  assign bus.o_valid   = valid_q;
  assign bus.o_seg_err = seg_err_q;
  assign bus.o_blank   = blank_o;
  assign bus.o_dot     = dot_o;

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Bench for fnd_scan_decoder: directed scans plus random scan streams,
// checked against a dwell-based frame model.
module tb_fnd_scan_decoder;

  localparam int S = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fnd_scan_decoder_if bus ();

  fnd_scan_decoder #(.STABLE_CYCLES(S)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int       value;
    bit       err;
    bit [3:0] blank;
    bit [3:0] dot;
  } frame_t;

  frame_t exp_q[$];
  frame_t obs_q[$];
  int n_vec = 0;
  int n_err = 0;

  // Model: a pin value counts once its uninterrupted dwell reaches S+1 cycles
  bit [11:0] m_cur;
  int        m_run;
  bit        m_acc;
  int        m_dig[4];
  bit [3:0]  m_blank, m_dot, m_mask;
  bit        m_err;
  logic [6:0] seg_tab[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic bit [7:0] seg8(input int d, input bit dp_lit);
    return {~dp_lit, seg_tab[d]};
  endfunction

  function automatic void model_clear();
    m_cur = 12'hFFF; m_run = 0; m_acc = 1'b1;
    m_mask = '0; m_blank = '0; m_dot = '0; m_err = 1'b0;
    for (int i = 0; i < 4; i++) m_dig[i] = 0;
  endfunction

  function automatic void model_capture(input bit [3:0] dg, input bit [7:0] dt);
    int p, d;
    bit blk;
    p = -1;
    for (int i = 0; i < 4; i++) begin
      bit [3:0] sel;
      sel = 4'b0001 << i;
      if (dg == ~sel) p = i;
    end
    if (p < 0) return;
    d = -1;
    for (int k = 0; k < 10; k++) if (dt[6:0] == seg_tab[k]) d = k;
    blk = (dt[6:0] == 7'h7F);
    if (d < 0) begin
      if (!blk) m_err = 1'b1;
      d = 0;
    end
    m_dig[p]   = d;
    m_blank[p] = blk;
`ifdef FND_DP_CAPTURE_EN
    m_dot[p]   = ~dt[7];
`else
    m_dot[p]   = 1'b0;
`endif
    m_mask[p]  = 1'b1;
    if (m_mask == 4'hF) begin
      exp_q.push_back('{m_dig[3]*1000 + m_dig[2]*100 + m_dig[1]*10 + m_dig[0],
                        m_err, m_blank, m_dot});
      m_mask = '0;
      m_err  = 1'b0;
    end
  endfunction

  // Hold one pin value for n clock cycles and advance the model
  task automatic step(input bit [3:0] dg, input bit [7:0] dt, input int n);
    bus.fnd_digit = dg;
    bus.fnd_data  = dt;
    repeat (n) @(posedge clk);
    #1;
    if ({dg, dt} != m_cur) begin
      m_cur = {dg, dt}; m_run = 0; m_acc = 1'b0;
    end
    m_run += n;
    if (!m_acc && m_run >= S + 1) begin
      m_acc = 1'b1;
      model_capture(dg, dt);
    end
  endtask

  task automatic do_reset(input int n);
    bus.fnd_digit = 4'hF;
    bus.fnd_data  = 8'hFF;
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
  endtask

  // Frame monitor
  always @(negedge clk)
    if (!reset && bus.o_valid)
      obs_q.push_back('{int'(bus.o_value), bus.o_seg_err, bus.o_blank, bus.o_dot});

  // Let the pipeline drain, then compare observed frames against the model
  task automatic check_frames(input string name);
    int n;
    step(4'hF, 8'hFF, 2 * S + 10);
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL %s frame count: got %0d want %0d", name, obs_q.size(), exp_q.size());
    end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      n_vec++;
      if (obs_q[i].value !== exp_q[i].value || obs_q[i].err !== exp_q[i].err ||
          obs_q[i].blank !== exp_q[i].blank || obs_q[i].dot !== exp_q[i].dot) begin
        n_err++;
        $display("FAIL %s frame %0d: got v=%0d e=%0b b=%b d=%b want v=%0d e=%0b b=%b d=%b",
                 name, i, obs_q[i].value, obs_q[i].err, obs_q[i].blank, obs_q[i].dot,
                 exp_q[i].value, exp_q[i].err, exp_q[i].blank, exp_q[i].dot);
      end
    end
    if (exp_q.size() > 0) begin
      frame_t last;
      last = exp_q[exp_q.size()-1];
      n_vec++;
      if (int'(bus.o_value) !== last.value || bus.o_valid !== 1'b0) begin
        n_err++;
        $display("FAIL %s hold: got v=%0d valid=%0b want v=%0d valid=0",
                 name, bus.o_value, bus.o_valid, last.value);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    int vcount, nz;
    vcount = 0; nz = 0;
    bus.fnd_digit = 4'hF;
    bus.fnd_data  = 8'hFF;
    reset = 1'b1;
    model_clear();
    repeat (100) begin
      @(negedge clk);
      if (bus.o_valid) vcount++;
      if (bus.o_value != 0 || bus.o_seg_err || bus.o_blank != 0 || bus.o_dot != 0) nz++;
    end
    n_vec++;
    if (vcount !== 0) begin n_err++; $display("FAIL reset valid pulses: got %0d want 0", vcount); end
    n_vec++;
    if (nz !== 0) begin n_err++; $display("FAIL reset outputs nonzero cycles: got %0d want 0", nz); end
    @(posedge clk); #1 reset = 1'b0;
    step(4'hF, 8'hFF, 20);
    n_vec++;
    if (bus.o_value !== 14'd0 || bus.o_seg_err !== 1'b0 || bus.o_blank !== 4'b0000 ||
        bus.o_dot !== 4'b0000 || obs_q.size() != 0) begin
      n_err++;
      $display("FAIL idle after reset: got v=%0d e=%0b b=%b d=%b frames=%0d want all 0",
               bus.o_value, bus.o_seg_err, bus.o_blank, bus.o_dot, obs_q.size());
    end
  endtask

  task automatic test_1234();
    step(4'b1110, 8'h99, 10);
    step(4'b1101, 8'hB0, 10);
    step(4'b1011, 8'hA4, 10);
    step(4'b0111, 8'hF9, 10);
    check_frames("scan1234");
    n_vec++;
    if (bus.o_value !== 14'd1234 || bus.o_seg_err !== 1'b0 || bus.o_blank !== 4'b0000) begin
      n_err++;
      $display("FAIL scan1234 direct: got v=%0d e=%0b b=%b want 1234 0 0000",
               bus.o_value, bus.o_seg_err, bus.o_blank);
    end
  endtask

  task automatic test_short_dwell();
    step(4'b1110, 8'h99, 3);
    step(4'hF, 8'hFF, 3);
    step(4'b1101, 8'hB0, 10);
    step(4'b1011, 8'hA4, 10);
    step(4'b0111, 8'hF9, 10);
    check_frames("short_dwell_no_emit");
    step(4'b1110, 8'h99, S + 2);
    check_frames("short_dwell_recapture");
  endtask

  task automatic test_seg_err();
    step(4'b1110, 8'h99, 10);
    step(4'b1101, 8'hB0, 10);
    step(4'b1011, 8'hFE, 10);
    step(4'b0111, 8'hF9, 10);
    check_frames("seg_err");
    n_vec++;
    if (bus.o_seg_err !== 1'b1 || bus.o_value !== 14'd1034) begin
      n_err++;
      $display("FAIL seg_err direct: got e=%0b v=%0d want 1 1034", bus.o_seg_err, bus.o_value);
    end
  endtask

  task automatic test_blank_dot();
    step(4'b0111, 8'hFF, 10);
    step(4'b1011, seg8(5, 0), 10);
    step(4'b1101, seg8(6, 0), 10);
    step(4'b1110, seg8(7, 0), 10);
    check_frames("blank_thousands");
    n_vec++;
    if (bus.o_value !== 14'd567 || bus.o_blank !== 4'b1000) begin
      n_err++;
      $display("FAIL blank direct: got v=%0d b=%b want 567 1000", bus.o_value, bus.o_blank);
    end
    step(4'b0111, 8'h00, 10);
    step(4'b1011, seg8(5, 0), 10);
    step(4'b1101, 8'h7F, 10);
    step(4'b1110, seg8(7, 0), 10);
    check_frames("dot_tens");
    n_vec++;
`ifdef FND_DP_CAPTURE_EN
    if (bus.o_dot !== 4'b1010 || bus.o_blank !== 4'b0010 || bus.o_value !== 14'd8507) begin
      n_err++;
      $display("FAIL dot direct: got d=%b b=%b v=%0d want 1010 0010 8507",
               bus.o_dot, bus.o_blank, bus.o_value);
    end
`else
    if (bus.o_dot !== 4'b0000 || bus.o_blank !== 4'b0010 || bus.o_value !== 14'd8507) begin
      n_err++;
      $display("FAIL dot direct: got d=%b b=%b v=%0d want 0000 0010 8507",
               bus.o_dot, bus.o_blank, bus.o_value);
    end
`endif
  endtask

  task automatic test_reset_mid();
    step(4'b1110, 8'h99, 10);
    step(4'b1101, 8'hB0, 10);
    do_reset(3);
    step(4'b1110, 8'h90, 10);
    step(4'b1101, 8'h90, 10);
    step(4'b1011, 8'h90, 10);
    step(4'b0111, 8'h90, 10);
    n_vec++;
    if (exp_q.size() != 1 || obs_q.size() != 1) begin
      n_err++;
      $display("FAIL reset_mid count: got %0d want 1 (model %0d)", obs_q.size(), exp_q.size());
    end
    check_frames("reset_mid");
    n_vec++;
    if (bus.o_value !== 14'd9999) begin
      n_err++;
      $display("FAIL reset_mid direct: got v=%0d want 9999", bus.o_value);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bit [3:0] dg;
      bit [7:0] dt;
      int kind;
      if ($urandom_range(0, 9) != 0) dg = ~(4'b0001 << $urandom_range(0, 3));
      else                           dg = 4'($urandom);
      kind = $urandom_range(0, 11);
      if (kind < 10)       dt = seg8(kind, 1'($urandom));
      else if (kind == 10) dt = {1'($urandom), 7'h7F};
      else                 dt = 8'($urandom);
      step(dg, dt, $urandom_range(2, 10));
      if (i % 100 == 99) check_frames("random");
    end
  endtask

  initial begin
    bus.fnd_digit = 4'hF;
    bus.fnd_data  = 8'hFF;
    test_reset();
    test_1234();
    test_short_dwell();
    test_seg_err();
    test_blank_dot();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
